// File: rtl/prbs_stream_checker_pkg.sv
// Shared definitions for the PRBS checker and its generator tile:
// FSM state encoding and the default stream polynomial.
package prbs_stream_checker_pkg;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // x^16+x^5+x^3+x^2+1 stream; the generator tile uses the same constants
    localparam int          DEF_WIDTH    = 16;
    localparam logic [15:0] DEF_TAP_MASK = 16'hB400;

endpackage

// File: rtl/prbs_stream_checker_predictor.sv
// History shift register for the PRBS checker; predicts the next stream bit
// from the tapped history and flags an all-zero history.
module prbs_predictor
    import prbs_stream_checker_pkg::*;
#(
    parameter int             WIDTH    = DEF_WIDTH,
    parameter logic [WIDTH-1:0] TAP_MASK = WIDTH'(DEF_TAP_MASK)
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_shift,
    input  logic i_bit,
    output logic o_pred,
    output logic o_hist_zero
);

    logic [WIDTH-1:0] r_hist;

    // r_hist[0] is the newest received bit
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hist <= '0;
        end else if (i_shift) begin
            r_hist <= {r_hist[WIDTH-2:0], i_bit};
        end
    end

    assign o_pred      = ^(r_hist & TAP_MASK);
    assign o_hist_zero = (r_hist == '0);

endmodule

// File: rtl/prbs_stream_checker.sv
// Self-synchronising PRBS stream checker on the 8-in/8-out tile pinout:
// hunts, syncs, reports lock and counts bit errors once locked.
module prbs_stream_checker
    import prbs_stream_checker_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] TAP_MASK  = WIDTH'(DEF_TAP_MASK),
    parameter int               LOCK_LEN  = 32,
    parameter int               LOSS_ERRS = 4,
    parameter int               WINDOW    = 64,
    parameter int               CNT_W     = 6
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    localparam int FILL_W  = $clog2(WIDTH + 1);
    localparam int MATCH_W = $clog2(LOCK_LEN + 1);
    localparam int WIN_W   = $clog2(WINDOW);
    localparam int WEC_W   = $clog2(LOSS_ERRS + 1);

    logic w_clk, w_rst, w_bit, w_vld, w_clr;
    logic w_unused;
    logic w_pred, w_hist_zero, w_mis, w_wrap, w_locked;
    logic [WEC_W-1:0] w_wec_next;

    state_t             r_state;
    logic [FILL_W-1:0]  r_fill;
    logic [MATCH_W-1:0] r_match;
    logic [WIN_W-1:0]   r_win;
    logic [WEC_W-1:0]   r_wec;
    logic [CNT_W-1:0]   r_err_cnt;
    logic               r_err_pulse;

    assign w_clk    = io_in[0];
    assign w_rst    = io_in[1];
    assign w_bit    = io_in[2];
    assign w_vld    = io_in[3];
    assign w_clr    = io_in[4];
    assign w_unused = ^io_in[7:5];

    prbs_predictor #(
        .WIDTH    (WIDTH),
        .TAP_MASK (TAP_MASK)
    ) u_pred (
        .i_clk       (w_clk),
        .i_rst       (w_rst),
        .i_shift     (w_vld),
        .i_bit       (w_bit),
        .o_pred      (w_pred),
        .o_hist_zero (w_hist_zero)
    );

    // An all-zero history never counts as a match, so a stuck-0 line cannot lock
    assign w_mis      = (w_bit != w_pred) || w_hist_zero;
    assign w_wrap     = (r_win == WIN_W'(WINDOW - 1));
    assign w_wec_next = w_wrap ? WEC_W'(w_mis) : r_wec + WEC_W'(w_mis);
    assign w_locked   = (r_state == ST_LOCKED);

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            r_state     <= ST_HUNT;
            r_fill      <= '0;
            r_match     <= '0;
            r_win       <= '0;
            r_wec       <= '0;
            r_err_cnt   <= '0;
            r_err_pulse <= 1'b0;
        end else begin
            r_err_pulse <= 1'b0;
            if (w_vld) begin
                case (r_state)
                    ST_HUNT: begin
                        r_fill <= r_fill + 1'b1;
                        if (r_fill == FILL_W'(WIDTH - 1)) begin
                            r_state <= ST_SYNC;
                            r_match <= '0;
                        end
                    end
                    ST_SYNC: begin
                        if (w_mis) begin
                            r_match <= '0;
                        end else if (r_match == MATCH_W'(LOCK_LEN - 1)) begin
                            r_match <= MATCH_W'(LOCK_LEN);
                            r_state <= ST_LOCKED;
                            r_win   <= '0;
                            r_wec   <= '0;
                        end else begin
                            r_match <= r_match + 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        // an error on the wrap bit is charged to the new window
                        r_win <= w_wrap ? '0 : r_win + 1'b1;
                        r_wec <= w_wec_next;
                        if (w_mis) begin
                            r_err_pulse <= 1'b1;
                            if (r_err_cnt != {CNT_W{1'b1}}) begin
                                r_err_cnt <= r_err_cnt + 1'b1;
                            end
                        end
                        if (w_wec_next == WEC_W'(LOSS_ERRS)) begin
                            r_state <= ST_HUNT;
                            r_fill  <= '0;
                        end
                    end
                    default: r_state <= ST_HUNT;
                endcase
            end
            if (w_clr) begin
                r_err_cnt <= '0;
            end
        end
    end

    assign io_out = {w_locked, r_err_pulse, r_err_cnt};

endmodule

// File: tb/tb_prbs_stream_checker.sv
// Directed bench for prbs_stream_checker with a behavioural reference model
// feeding a scoreboard of expected io_out values.
module tb_prbs_stream_checker;

    localparam logic [15:0] MASK = 16'hB400;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rxb = 1'b0;
    logic rxv = 1'b0;
    logic clr = 1'b0;
    logic [7:0] io_in;
    logic [7:0] io_out;

    // io_in[7:5] held non-zero: the design must ignore them
    assign io_in = {3'b101, clr, rxv, rxb, rst, clk};

    prbs_stream_checker dut (
        .io_in  (io_in),
        .io_out (io_out)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  sb_q[$];
    logic [15:0] g = 16'hACE1;
    int          pulse_cnt = 0;

    logic [15:0] m_hist;
    int          m_state, m_fill, m_match, m_win, m_wec, m_err, total_errs;
    logic        m_pulse;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hist = 16'h0; m_state = 0; m_fill = 0; m_match = 0;
        m_win = 0; m_wec = 0; m_err = 0; m_pulse = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic b, input logic c);
        logic pred, mis, np;
        np = 1'b0;
        if (v) begin
            pred = ^(m_hist & MASK);
            mis = (b !== pred) || (m_hist == 16'h0);
            m_hist = {m_hist[14:0], b};
            case (m_state)
                0: begin
                    m_fill++;
                    if (m_fill == 16) begin m_state = 1; m_match = 0; end
                end
                1: begin
                    if (mis) m_match = 0; else m_match++;
                    if (m_match == 32) begin m_state = 2; m_win = 0; m_wec = 0; end
                end
                default: begin
                    m_win++;
                    if (m_win == 64) begin m_win = 0; m_wec = 0; end
                    if (mis) begin
                        if (m_err < 63) m_err++;
                        m_wec++;
                        np = 1'b1;
                        total_errs++;
                    end
                    if (m_wec >= 4) begin m_state = 0; m_fill = 0; end
                end
            endcase
        end
        if (c) m_err = 0;
        m_pulse = np;
    endtask

    function automatic logic [7:0] m_out();
        logic [7:0] o;
        o[7]   = (m_state == 2);
        o[6]   = m_pulse;
        o[5:0] = m_err[5:0];
        return o;
    endfunction

    task automatic gen(output logic b);
        b = ^(g & MASK);
        g = {g[14:0], b};
    endtask

    // drive one cycle, predict, then compare one cycle later away from the edge
    task automatic step(input logic v, input logic b, input logic c);
        logic [7:0] e;
        rxv = v; rxb = b; clr = c;
        model_step(v, b, c);
        sb_q.push_back(m_out());
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("sb_out", io_out, e);
        if (io_out[6]) pulse_cnt++;
    endtask

    task automatic clean(input int n);
        logic b;
        for (int i = 0; i < n; i++) begin
            gen(b);
            step(1'b1, b, 1'b0);
        end
    endtask

    task automatic flip_one();
        logic b;
        gen(b);
        step(1'b1, ~b, 1'b0);
    endtask

    task automatic lock48(input string tag);
        logic b;
        for (int i = 1; i <= 48; i++) begin
            gen(b);
            step(1'b1, b, 1'b0);
            if (i == 47) chk({tag, "_not_early"}, io_out[7], 0);
            if (i == 48) chk({tag, "_at_48"}, io_out[7], 1);
        end
    endtask

    task automatic burst(output logic dropped);
        logic b, dummy;
        dropped = 1'b0;
        for (int i = 0; i < 64 && !dropped; i++) begin
            b = 1'($urandom_range(0, 1));
            gen(dummy);
            step(1'b1, b, 1'b0);
            if (io_out[7] == 1'b0) dropped = 1'b1;
        end
    endtask

    task automatic do_reset();
        #3;
        rst = 1'b1; rxv = 1'b0; clr = 1'b0;
        #1;
        chk("async_reset_out", io_out, 8'h00);
        model_reset();
        @(posedge clk);
        #1;
        chk("reset_hold_out", io_out, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b0);
            chk("idle_after_reset", io_out, 8'h00);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen_lock, dropped;
        total_errs = 0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // stuck-zero line never locks
        seen_lock = 1'b0;
        for (int i = 0; i < 500; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (io_out[7]) seen_lock = 1'b1;
        end
        chk("stuck0_never_locked", seen_lock, 0);

        // clean lock from reset, then 1000 clean bits in total
        do_reset();
        g = 16'hACE1;
        lock48("clean_lock");
        clean(952);
        chk("clean_err_zero", io_out[5:0], 0);
        chk("clean_still_locked", io_out[7], 1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);

        // single flip whose 5 errors straddle a window wrap (2 + 3)
        clean(59);
        pulse_cnt = 0;
        flip_one();
        clean(40);
        chk("single_err_cnt", io_out[5:0], 5);
        chk("single_err_pulses", pulse_cnt, 5);
        chk("single_keeps_lock", io_out[7], 1);

        // single flip whose errors all land in one window: 4th error drops lock
        clean(37);
        pulse_cnt = 0;
        flip_one();
        for (int n = 1139; n <= 1200; n++) begin
            clean(1);
            if (n == 1160) chk("window_drop_locked", io_out[7], 0);
            if (n == 1199) chk("window_relock_not_early", io_out[7], 0);
            if (n == 1200) chk("window_relock_at_48", io_out[7], 1);
        end
        chk("window_err_cnt", io_out[5:0], 9);
        chk("window_err_pulses", pulse_cnt, 4);

        // clr_err on an idle cycle
        step(1'b0, 1'b0, 1'b1);
        chk("idle_clr_cnt", io_out[5:0], 0);
        chk("idle_clr_keeps_lock", io_out[7], 1);

        // burst of random bits drops lock, clean data relocks after 48 bits
        burst(dropped);
        chk("burst_drop_within_64", dropped, 1);
        lock48("burst_relock");

        // repeated lock/burst episodes until the counter saturates
        for (int ep = 0; ep < 40 && total_errs < 100; ep++) begin
            burst(dropped);
            lock48("sat_relock");
        end
        chk("sat_hold_63", io_out[5:0], 63);

        // clr_err together with a locked mismatch
        begin
            logic b;
            gen(b);
            step(1'b1, ~b, 1'b1);
        end
        chk("clr_priority_cnt", io_out[5:0], 0);
        chk("clr_mis_pulse", io_out[6], 1);
        chk("clr_keeps_lock", io_out[7], 1);
        clean(20);

        // mid-stream reset, then relock from scratch
        do_reset();
        lock48("post_reset_lock");
        clean(30);
        chk("post_reset_err_zero", io_out[5:0], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
